// File: rtl/result_display_scan.sv
// result_display_scan: shows a double-buffered 16-bit word as four multiplexed hex digits
// on a common-anode 7-segment display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module result_display_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [15:0] value,
  input  logic        load,
  output logic        updated,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] count;
  logic [1:0]    idx;
  logic [1:0]    idxNext;
  logic [15:0]   shadow;
  logic [15:0]   shadowNext;
  logic [15:0]   pending;
  logic          pendFlag;
  logic          tick;
  logic          boundary;
  logic [3:0]    nibble;
  logic          blank;
  logic [6:0]    segNext;

  function automatic logic [6:0] hexToSeg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign tick     = (count == LAST);
  assign boundary = tick && (idx == 2'd3);
  assign idxNext  = idx + 2'd1;

  // The frame buffer only changes at a frame boundary; a load on that very cycle wins.
  always_comb begin
    shadowNext = shadow;
    if (boundary) begin
      if (load)
        shadowNext = value;
      else if (pendFlag)
        shadowNext = pending;
    end
  end

  // Decode uses the post-boundary buffer so digit 0 of a new frame shows the new word.
  always_comb begin
    nibble = shadowNext[{idxNext, 2'b00} +: 4];
    blank  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idxNext)
      2'd1:    blank = (shadowNext[15:4] == 12'h000);
      2'd2:    blank = (shadowNext[15:8] == 8'h00);
      2'd3:    blank = (shadowNext[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
    segNext = blank ? 7'b1111111 : hexToSeg(nibble);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count    <= '0;
      idx      <= 2'd0;
      shadow   <= 16'h0000;
      pending  <= 16'h0000;
      pendFlag <= 1'b0;
      an       <= 4'b1110;
      seg      <= 7'b1000000;
      updated  <= 1'b0;
    end else begin
      count   <= tick ? '0 : count + CW'(1);
      updated <= boundary && (load || pendFlag);
      shadow  <= shadowNext;
      if (boundary) begin
        pendFlag <= 1'b0;
      end else if (load) begin
        pending  <= value;
        pendFlag <= 1'b1;
      end
      if (tick) begin
        idx <= idxNext;
        an  <= ~(4'b0001 << idxNext);
        seg <= segNext;
      end
    end
  end
endmodule

// File: tb/tb_result_display_scan.sv
// Bench for result_display_scan: two instances (REFRESH_DIV=4 and 1) checked every cycle
// against a frame-level reference model, plus table vectors and directed corner sequences.
module tb_result_display_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear4, load4, upd4;
  logic [15:0] val4;
  logic [6:0]  seg4;
  logic [3:0]  an4;
  logic        clear1, load1, upd1;
  logic [15:0] val1;
  logic [6:0]  seg1;
  logic [3:0]  an1;

  result_display_scan #(.REFRESH_DIV(4)) dut4 (
    .clk(clk), .clear(clear4), .value(val4), .load(load4),
    .updated(upd4), .seg(seg4), .an(an4));

  result_display_scan #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .clear(clear1), .value(val1), .load(load1),
    .updated(upd1), .seg(seg1), .an(an1));

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    int          n;     // cycles since clear released
    logic [15:0] sh;    // word currently on display
    logic [15:0] pd;
    bit          fl;
    bit          upd;   // expected updated in current cycle
  } model_t;

  typedef struct {
    string       name;
    logic [15:0] val;
    logic [15:0] anx;   // {slot3,slot2,slot1,slot0}
    logic [27:0] segx;
  } vec_t;

  model_t      m4, m1;
  int          passCnt = 0;
  int          totalCnt = 0;
  logic [3:0]  sAn4;
  logic [6:0]  sSeg4;
  logic        sUpd4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] expSeg(input logic [15:0] sh, input int dig);
    logic [15:0] hi;
    hi = sh >> (4 * dig);
`ifdef LEADING_ZERO_BLANK_EN
    if (dig > 0 && hi == 16'h0) return 7'b1111111;
`endif
    return SEG_TAB[hi[3:0]];
  endfunction

  function automatic model_t mReset();
    model_t r;
    r.n = 0; r.sh = 16'h0; r.pd = 16'h0; r.fl = 1'b0; r.upd = 1'b0;
    return r;
  endfunction

  function automatic model_t mStep(input model_t m, input int div, input bit ld, input logic [15:0] v);
    int dig;
    bit bnd;
    dig = (m.n / div) % 4;
    bnd = (m.n % div == div - 1) && (dig == 3);
    m.upd = 1'b0;
    if (bnd) begin
      m.upd = ld || m.fl;
      if (ld) m.sh = v;
      else if (m.fl) m.sh = m.pd;
      m.fl = 1'b0;
    end else if (ld) begin
      m.pd = v;
      m.fl = 1'b1;
    end
    m.n++;
    return m;
  endfunction

  task automatic chkModel(input string tag, input model_t m, input int div,
                          input logic [3:0] a, input logic [6:0] s, input logic u);
    int dig;
    logic [3:0] ea;
    dig = (m.n / div) % 4;
    ea = ~(4'b0001 << dig);
    chk({tag, ".an"}, a, ea);
    chk({tag, ".seg"}, s, expSeg(m.sh, dig));
    chk({tag, ".updated"}, u, m.upd);
  endtask

  task automatic cycle(input bit c4, input bit l4, input logic [15:0] v4,
                       input bit c1, input bit l1, input logic [15:0] v1);
    clear4 = c4; load4 = l4; val4 = v4;
    clear1 = c1; load1 = l1; val1 = v1;
    if (c4) m4 = mReset();
    if (c1) m1 = mReset();
    @(negedge clk);
    sAn4 = an4; sSeg4 = seg4; sUpd4 = upd4;
    chkModel("m4", m4, 4, an4, seg4, upd4);
    chkModel("m1", m1, 1, an1, seg1, upd1);
    if (!c4) m4 = mStep(m4, 4, l4, v4);
    if (!c1) m1 = mStep(m1, 1, l1, v1);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc4(input bit c, input bit l, input logic [15:0] v);
    cycle(c, l, v, 1'b0, 1'b0, 16'h0);
  endtask

  vec_t tab [3];
  int   updCount;
  int   seen;
  int   slot;

  initial begin
    tab[0] = '{"hex12AF", 16'h12AF, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
`ifdef LEADING_ZERO_BLANK_EN
    tab[1] = '{"hex0005", 16'h0005, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}};
    tab[2] = '{"hex0000", 16'h0000, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
`else
    tab[1] = '{"hex0005", 16'h0005, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b1000000, 7'b1000000, 7'b1000000, 7'b0010010}};
    tab[2] = '{"hex0000", 16'h0000, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
`endif

    clear4 = 1'b1; clear1 = 1'b1;
    load4 = 1'b0; load1 = 1'b0; val4 = 16'h0; val1 = 16'h0;
    m4 = mReset(); m1 = mReset();
    @(posedge clk);
    #1;
    chk("reset.an", an4, 4'b1110);
    chk("reset.seg", seg4, 7'b1000000);
    chk("reset.updated", upd4, 1'b0);

    // Clear mid-scan while digit 2 is active, then check the restart.
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("midscan.an_before", an4, 4'b1011);
    cyc4(1'b1, 1'b0, 16'h0);
    chk("clear.an", sAn4, 4'b1110);
    chk("clear.seg", sSeg4, 7'b1000000);
    chk("clear.updated", sUpd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc4(1'b0, 1'b0, 16'h0);
      chk("restart.digit0", sAn4, 4'b1110);
    end
    cyc4(1'b0, 1'b0, 16'h0);
    chk("restart.digit1", sAn4, 4'b1101);

    // Table vectors: load at cycle 0, frame appears in cycles 16..31.
    for (int t = 0; t < 3; t++) begin
      cyc4(1'b1, 1'b0, 16'h0);
      updCount = 0;
      for (int k = 0; k < 48; k++) begin
        cyc4(1'b0, k == 0, tab[t].val);
        updCount += int'(sUpd4);
        if (k >= 16 && k < 32) begin
          slot = (k - 16) / 4;
          chk({tab[t].name, ".an"}, sAn4, tab[t].anx[slot*4 +: 4]);
          chk({tab[t].name, ".seg"}, sSeg4, tab[t].segx[slot*7 +: 7]);
        end
      end
      chk({tab[t].name, ".updCount"}, updCount, 1);
    end

    // Two loads before the boundary: last one wins, single update.
    cyc4(1'b1, 1'b0, 16'h0);
    updCount = 0; seen = 0;
    for (int k = 0; k < 48; k++) begin
      cyc4(1'b0, (k == 0) || (k == 3), (k == 0) ? 16'h1111 : 16'h2222);
      updCount += int'(sUpd4);
      if (sSeg4 == 7'b1111001) seen++;
      if (k == 16) chk("lastwins.digit0", sSeg4, 7'b0100100);
    end
    chk("lastwins.updCount", updCount, 1);
    chk("lastwins.never1111", seen, 0);

    // Load on the boundary cycle itself discards the older pending word.
    cyc4(1'b1, 1'b0, 16'h0);
    updCount = 0; seen = 0;
    for (int k = 0; k < 48; k++) begin
      cyc4(1'b0, (k == 0) || (k == 15), (k == 0) ? 16'h0001 : 16'hBEEF);
      updCount += int'(sUpd4);
      if (k >= 16 && sSeg4 == 7'b1111001) seen++;
      if (k == 16) begin
        chk("bndload.updated", sUpd4, 1'b1);
        chk("bndload.digit0", sSeg4, 7'b0001110);
      end
    end
    chk("bndload.updCount", updCount, 1);
    chk("bndload.never0001", seen, 0);

    // REFRESH_DIV=1 sweep: every digit sees all 16 nibble values.
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    for (int s = 0; s < 17; s++) begin
      logic [15:0] w;
      for (int d = 0; d < 4; d++) w[d*4 +: 4] = 4'((s + 4 * d) % 16);
      for (int k = 0; k < 4; k++)
        cycle(1'b0, 1'b0, 16'h0, 1'b0, (k == 0) && (s < 16), w);
    end

    // Random loads and occasional clears on both instances.
    for (int k = 0; k < 800; k++) begin
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0, 16'($urandom),
            $urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0, 16'($urandom));
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
